// File: rtl/rv32_mem_pkg.sv
// Shared memory-side types and default widths for the rv32pipe3 memory path
// (arbiter, imem/dmem wrappers).
package rv32_mem_pkg;

    localparam int unsigned MEM_AW           = 10;
    localparam int unsigned MEM_DW           = 32;
    localparam int unsigned MAX_DATA_RUN_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and shared-memory signals of the memory port arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_port_arbiter_if
    import rv32_mem_pkg::*;
#(
    parameter int unsigned AW = MEM_AW,
    parameter int unsigned DW = MEM_DW
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports: data has priority,
// fetch is forced in after MAX_DATA_RUN consecutive data grants while it waits.
module mem_port_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int unsigned AW           = MEM_AW,
    parameter int unsigned DW           = MEM_DW,
    parameter int unsigned MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned RW = $clog2(MAX_DATA_RUN + 1);

    arb_state_t    r_state,     w_state_nxt;
    owner_t        r_owner,     w_owner_nxt;
    logic [RW-1:0] r_run,       w_run_nxt;
    logic          r_mem_en,    w_mem_en_nxt;
    logic          r_mem_we,    w_mem_we_nxt;
    logic [AW-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic          r_if_ready,  w_if_ready_nxt;
    logic [DW-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic          r_d_ready,   w_d_ready_nxt;
    logic [DW-1:0] r_d_rdata,   w_d_rdata_nxt;

    logic w_req_any;
    logic w_grant_if;

    assign w_req_any  = bus.if_req | bus.d_req;
    assign w_grant_if = bus.if_req & (~bus.d_req | (r_run == RW'(MAX_DATA_RUN)));

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= OWN_NONE;
            r_run       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ready  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_ready   <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_run       <= w_run_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_ready  <= w_if_ready_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_ready   <= w_d_ready_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req_any)   w_state_nxt = BUSY;
            BUSY:    if (bus.mem_ack) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant, memory sequencing, result capture and ready pulses
    always_comb begin
        w_owner_nxt     = r_owner;
        w_mem_en_nxt    = r_mem_en;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_ready_nxt  = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_ready_nxt   = 1'b0;
        w_d_rdata_nxt   = r_d_rdata;
        case (r_state)
            IDLE: begin
                if (w_req_any) begin
                    w_mem_en_nxt = 1'b1;
                    if (w_grant_if) begin
                        w_owner_nxt    = OWN_IF;
                        w_mem_addr_nxt = bus.if_addr;
                        w_mem_we_nxt   = 1'b0;
                    end else begin
                        w_owner_nxt     = OWN_D;
                        w_mem_addr_nxt  = bus.d_addr;
                        w_mem_we_nxt    = bus.d_we;
                        w_mem_wdata_nxt = bus.d_wdata;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    w_mem_en_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    if (r_owner == OWN_IF) begin
                        w_if_rdata_nxt = bus.mem_rdata;
                        w_if_ready_nxt = 1'b1;
                    end else if (r_owner == OWN_D) begin
                        if (!r_mem_we) w_d_rdata_nxt = bus.mem_rdata;
                        w_d_ready_nxt = 1'b1;
                    end
                end
            end
            DONE:    w_owner_nxt = OWN_NONE;
            default: w_owner_nxt = OWN_NONE;
        endcase
    end

    // Consecutive data grants while fetch is waiting
    always_comb begin
        w_run_nxt = r_run;
        if (!bus.if_req) begin
            w_run_nxt = '0;
        end else if (r_state == IDLE && w_req_any) begin
            if (w_grant_if)                        w_run_nxt = '0;
            else if (r_run != RW'(MAX_DATA_RUN))   w_run_nxt = r_run + RW'(1);
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_ready  = r_if_ready;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_ready   = r_d_ready;
    assign bus.d_rdata   = r_d_rdata;

endmodule
